pipe_stage_skid: RTL and testbench

//   Parametrised inter-stage pipeline register for the CPU datapath (ID/EXE, EXE/MEM, ...).

---
 rtl/pipe_stage_skid.sv | 115 +++++++++++
 tb/tb_pipe_stage_skid.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with stall, flush, bubble insertion and optional skid entry
module pipe_stage_skid #(
  parameter int DATA_W  = 128,
  parameter int STALL_W = 6,
  parameter int STAGE   = 2,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // State index doubles as the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  bubble_q;

  logic stall_in;
  logic stall_out;
  logic acc;
  logic take;
  logic unused_stall;

  assign stall_in = stall[STAGE];

  // The last stage in the vector has no downstream stall bit.
  if (STAGE + 1 < STALL_W) begin : g_stall_out
    assign stall_out = stall[STAGE+1];
  end else begin : g_no_stall_out
    assign stall_out = 1'b0;
  end

  // Other stages' stall bits are deliberately ignored here.
  assign unused_stall = ^stall;

  assign out_valid  = (state != EMPTY);
  assign out_data   = main_q;
  assign occupancy  = state;
  assign bubble_cnt = bubble_q;

  assign take = out_valid & out_ready & ~stall_out;

  // With the skid entry, in_ready depends on state only, breaking the out_ready -> in_ready path.
  assign in_ready = (SKID_EN != 0) ? (state != FULL) : ((state == EMPTY) | take);

  assign acc = in_valid & in_ready & ~stall_in;

  // Entry state machine; main always holds the head entry and is zero whenever empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (acc && take) begin
            main_q <= in_data;
          end else if (acc && (SKID_EN != 0)) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (take) begin
            state  <= EMPTY;
            main_q <= '0;
          end
        end
        FULL: begin
          if (take) begin
            state  <= ONE;
            main_q <= skid_q;
            skid_q <= '0;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles where downstream was willing but got nothing; survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (!out_valid && out_ready && !stall_out && (bubble_q != '1)) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DATA_W  = 8;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_ready;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   bubble_cnt;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [DATA_W-1:0] sb_q[$];

  pipe_stage_skid #(
    .DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE(2), .SKID_EN(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard at the negedge, then advance past the next posedge.
  task automatic cycle();
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready && !stall[3]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %0h want nothing", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          popped++;
          if (out_data !== exp_d) begin
            errors++;
            $display("FAIL sb_data got %0h want %0h", out_data, exp_d);
          end
        end
      end
      if (in_valid && in_ready && !stall[2]) begin
        sb_q.push_back(in_data);
        pushed++;
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== '0) begin
          errors++;
          $display("FAIL idle_zero got %0h want 0", out_data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h want 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    checks++; if (bubble_cnt !== 4'h0) begin errors++; $display("FAIL rst_bubble got %0h want 0", bubble_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL t1_data got %0h want a5", out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL t1_occ got %0d want 1", occupancy); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL t1_drain_occ got %0d want 0", occupancy); end
    checks++; if (bubble_cnt !== 4'h0) begin errors++; $display("FAIL t1_bubble got %0h want 0", bubble_cnt); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; cycle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t2_ready1 got %0b want 1", in_ready); end
    in_data = 8'h02; cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t2_ready2 got %0b want 0", in_ready); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL t2_occ_full got %0d want 2", occupancy); end
    in_data = 8'h03; cycle();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL t2_occ_held got %0d want 2", occupancy); end
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL t2_head got %0h want 01", out_data); end
    out_ready = 1'b1; cycle();
    checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL t2_second got %0h want 02", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t2_ready3 got %0b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h03) begin errors++; $display("FAIL t2_third got %0h want 03", out_data); end
    cycle();
    out_ready = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL t2_occ_end got %0d want 0", occupancy); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t2_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 1'b1; in_data = 8'h55; cycle();
    stall = 6'b000100; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h66;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL t3_data got %0h want 0", out_data); end
    cycle();
    checks++; if (bubble_cnt !== 4'h1) begin errors++; $display("FAIL t3_bubble got %0h want 1", bubble_cnt); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL t3_occ got %0d want 0", occupancy); end
    in_valid = 1'b0; stall = '0; out_ready = 1'b0;
  endtask

  task automatic test_hold();
    in_valid = 1'b1; in_data = 8'h55; cycle();
    stall = 6'b001100; out_ready = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL t4_data[%0d] got %0h want 55", i, out_data); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL t4_occ[%0d] got %0d want 1", i, occupancy); end
      checks++; if (bubble_cnt !== 4'h1) begin errors++; $display("FAIL t4_bubble[%0d] got %0h want 1", i, bubble_cnt); end
    end
    in_valid = 1'b0; stall = '0;
    cycle();
    out_ready = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL t4_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hAA; cycle();
    in_data = 8'hBB; cycle();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL t5_full got %0d want 2", occupancy); end
    flush = 1'b1; in_data = 8'hCC; cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL t5_occ got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL t5_data got %0h want 0", out_data); end
    out_ready = 1'b1; cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_ghost got %0b want 0", out_valid); end
    checks++; if (bubble_cnt !== 4'h2) begin errors++; $display("FAIL t5_bubble got %0h want 2", bubble_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    pushed = 0; popped = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = {2'b00, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 2'b00};
      cycle();
    end
    in_valid = 1'b0; stall = '0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_occ got %0d want 0", occupancy); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_sb_left got %0d want 0", sb_q.size()); end
    checks++; if (popped != pushed || pushed < 50) begin
      errors++; $display("FAIL b2b_count got %0d delivered want %0d accepted (min 50)", popped, pushed);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if (bubble_cnt !== ((i < 15) ? 4'(i) : 4'hF)) begin
        errors++; $display("FAIL t6_bubble[%0d] got %0h want %0h", i, bubble_cnt, (i < 15) ? 4'(i) : 4'hF);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_skid();
    test_bubble();
    test_hold();
    test_flush();
    test_back_to_back();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
